// File: rtl/window_addr_gen.sv
// Sliding-window read-address generator: scans every KxK window of an IMG_W x IMG_H
// row-major image. Define STRIDE2_EN to move window origins by 2 instead of 1.
module window_addr_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int ADD_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             READY,
  output logic [ADD_W-1:0] ADDR,
  output logic             ADDR_VALID,
  output logic             WIN_LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MAX_D = (IMG_W > IMG_H) ? IMG_W : IMG_H;
  localparam int CW    = $clog2(MAX_D + 1);
`ifdef STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int COL_LAST = ((IMG_W - K) / STRIDE) * STRIDE;
  localparam int ROW_LAST = ((IMG_H - K) / STRIDE) * STRIDE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    kc_q, kc_d, kr_q, kr_d, col_q, col_d, row_q, row_d;
  logic [ADD_W-1:0] addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs_s;

  function automatic logic [ADD_W-1:0] lin_addr(input logic [CW-1:0] r, input logic [CW-1:0] kr,
                                                input logic [CW-1:0] c, input logic [CW-1:0] kc);
    logic [31:0] full;
    full = (32'(r) + 32'(kr)) * 32'(IMG_W) + 32'(c) + 32'(kc);
    return full[ADD_W-1:0];
  endfunction

  assign hs_s = valid_q & READY;

  // Next-state and counter advance; all outputs are re-derived from the next counters.
  always_comb begin
    state_d = state_q;
    kc_d    = kc_q;
    kr_d    = kr_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        kc_d  = {CW{1'b0}};
        kr_d  = {CW{1'b0}};
        col_d = {CW{1'b0}};
        row_d = {CW{1'b0}};
        if (START) begin
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (hs_s) begin
          if (kc_q == CW'(K - 1)) begin
            kc_d = {CW{1'b0}};
            if (kr_q == CW'(K - 1)) begin
              kr_d = {CW{1'b0}};
              if (col_q == CW'(COL_LAST)) begin
                col_d = {CW{1'b0}};
                if (row_q == CW'(ROW_LAST)) begin
                  row_d   = {CW{1'b0}};
                  state_d = ST_FIN;
                end else begin
                  row_d = row_q + CW'(STRIDE);
                end
              end else begin
                col_d = col_q + CW'(STRIDE);
              end
            end else begin
              kr_d = kr_q + CW'(1);
            end
          end else begin
            kc_d = kc_q + CW'(1);
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        kc_d    = {CW{1'b0}};
        kr_d    = {CW{1'b0}};
        col_d   = {CW{1'b0}};
        row_d   = {CW{1'b0}};
      end
    endcase
  end

  // Output next values: ADDR is only meaningful in SCAN and reads 0 elsewhere.
  always_comb begin
    valid_d = (state_d == ST_SCAN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
    last_d  = valid_d && (kc_d == CW'(K - 1)) && (kr_d == CW'(K - 1));
    if (valid_d) begin
      addr_d = lin_addr(row_d, kr_d, col_d, kc_d);
    end else begin
      addr_d = {ADD_W{1'b0}};
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      kc_q    <= {CW{1'b0}};
      kr_q    <= {CW{1'b0}};
      col_q   <= {CW{1'b0}};
      row_q   <= {CW{1'b0}};
      addr_q  <= {ADD_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      kr_q    <= kr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ADDR       = addr_q;
  assign ADDR_VALID = valid_q;
  assign WIN_LAST   = last_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: doc/window_addr_gen.md
WINDOW_ADDR_GEN -- requirements
Module: window_addr_gen

Interface
REQ-001 Parameter IMG_W, default 28, image width in pixels.
REQ-002 Parameter IMG_H, default 28, image height in pixels.
REQ-003 Parameter K, default 3, square kernel size; 1 <= K <= min(IMG_W, IMG_H).
REQ-004 Parameter ADD_W, default 10, address width; the required minimum is 2^ADD_W >= IMG_W*IMG_H.
REQ-005 CLK  input  1  clock; all state SHALL update on the rising edge only.
REQ-006 RST  input  1  reset, synchronous, active-low.
REQ-007 START  input  1  begin a full-image scan; sampled only in IDLE.
REQ-008 READY  input  1  downstream (pixel BRAM / MAC) accepts ADDR this cycle.
REQ-009 ADDR  output  ADD_W  linear pixel read address, row-major.
REQ-010 ADDR_VALID  output  1  ADDR is valid.
REQ-011 WIN_LAST  output  1  ADDR is the final (K-1,K-1) element of the current window.
REQ-012 BUSY  output  1  high in SCAN and DONE states.
REQ-013 DONE  output  1  one-cycle pulse after the final handshake of the image.

Function
REQ-014 The FSM SHALL have the states IDLE, SCAN and FIN and no others.
REQ-015 IDLE: START=1 -> SCAN next cycle, with all counters cleared; START=0 -> remain in IDLE.
REQ-016 Four internal counters SHALL be kept, ordered innermost to outermost: kc (0..K-1), kr (0..K-1), col (window origin), row (window origin).
REQ-017 A handshake SHALL occur on any cycle where ADDR_VALID=1 and READY=1; counters SHALL advance only on a handshake.
REQ-018 ADDR SHALL equal (row+kr)*IMG_W + (col+kc), truncated to ADD_W bits.
REQ-019 ADDR SHALL be derived from registers only, with no combinational path from READY or START.
REQ-020 ADDR_VALID SHALL be 1 in SCAN and 0 in IDLE and FIN.
REQ-021 With READY=0, ADDR, ADDR_VALID and WIN_LAST SHALL hold unchanged.
REQ-022 Counter advance: kc wraps to 0 at K-1 and carries into kr; kr wraps and carries into col; col wraps at its last origin and carries into row.
REQ-023 The last origins SHALL be col = IMG_W-K and row = IMG_H-K (stride 1).
REQ-024 WIN_LAST SHALL be 1 exactly when kc=K-1 and kr=K-1 in SCAN.
REQ-025 A handshake on the final element (last row, last col, kr=kc=K-1) SHALL cause SCAN -> FIN.
REQ-026 FIN SHALL assert DONE for one cycle and then move to IDLE.
REQ-027 START asserted in SCAN or FIN SHALL be ignored.
REQ-028 The first address SHALL be presented the cycle after START is sampled, so start-to-ADDR_VALID latency is 1 cycle.
REQ-029 With continuous READY=1, there SHALL be one address per cycle and no bubbles between windows or rows.

Reset
REQ-030 When RST=0 at a rising edge, the state SHALL become IDLE and all counters 0.
REQ-031 During reset, ADDR, ADDR_VALID, WIN_LAST, BUSY and DONE SHALL all be 0.
REQ-032 Reset asserted mid-scan SHALL abandon the scan with no DONE pulse.
REQ-033 After release from a mid-scan reset, a new START SHALL restart the scan at address 0.

Configuration
REQ-034 The macro STRIDE2_EN SHALL select the window stride.
REQ-035 With STRIDE2_EN defined, col and row SHALL advance by 2.
REQ-036 With STRIDE2_EN defined, the last origins SHALL be 2*floor((IMG_W-K)/2) for col and 2*floor((IMG_H-K)/2) for row.
REQ-037 With STRIDE2_EN undefined, the stride SHALL be 1 as in REQ-023.

Verification
REQ-038 Defaults, READY=1, START pulse -> the first nine ADDR values are 0,1,2,28,29,30,56,57,58; WIN_LAST is set on the 9th.
REQ-039 Defaults, READY=1 -> 6084 handshakes and final ADDR 783, then DONE high for exactly 1 cycle and BUSY low the following cycle.
REQ-040 IMG_W=5, IMG_H=4, K=3, READY toggling randomly -> exactly 54 handshakes, sequence identical to the READY=1 run, and ADDR stable while READY=0.
REQ-041 RST=0 at handshake 100 of a default scan -> all outputs 0 the next cycle and no DONE; a new START then yields ADDR 0 first.
REQ-042 START held high throughout a scan -> no restart; DONE pulses once, then a new scan begins from IDLE.
REQ-043 STRIDE2_EN defined, IMG_W=5, IMG_H=4, K=3 -> 18 handshakes; the second window's first ADDR is 2; the final ADDR is 14.
